// File: rtl/arb_req_frontend4.sv
// -----------------------------------------------------------------------------
// arb_req_frontend4
//
// Four-channel synchronous request front end for a four-way tree arbiter.
// Each client's clocked level request becomes a four-phase R/A handshake
// toward the arbiter. The asynchronous acknowledges are synchronised, a
// registered grant is issued to the client, grant hold time is bounded, and
// any mutual-exclusion violation on the synchronised acknowledges is flagged.
//
// Parameters:
//   SYNC_STAGES  flops per acknowledge synchroniser (2..4)
//   MAX_HOLD     maximum GRANT cycles before forced release (1..255)
//
// Ports:
//   clk             single clock, all state on rising edge
//   rst             asynchronous active-high reset
//   req[3:0]        client level requests, bit i-1 -> channel i
//   done[3:0]       client release strobes, honoured only in GRANT
//   A4..A1          asynchronous acknowledges from the arbiter
//   R4..R1          registered requests to the arbiter
//   grant[3:0]      registered per-channel grant to clients
//   timeout[3:0]    sticky per-channel hold-timeout flag
//   abort[3:0]      sticky per-channel aborted-request flag
//   excl_err        sticky flag: two or more synchronised acknowledges high
// -----------------------------------------------------------------------------
module arb_req_frontend4 #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_HOLD    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    input  logic       A4,
    input  logic       A3,
    input  logic       A2,
    input  logic       A1,
    output logic       R4,
    output logic       R3,
    output logic       R2,
    output logic       R1,
    output logic [3:0] grant,
    output logic [3:0] timeout,
    output logic [3:0] abort,
    output logic       excl_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2,
        REL   = 2'd3
    } state_t;

    // Counter value on which an unreleased grant is forced off; the grant
    // then lasts exactly MAX_HOLD cycles.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [3:0] a_in;   // raw asynchronous acknowledges
    logic [3:0] a_s;    // synchronised acknowledges, seen by the FSMs
    logic [3:0] a_pre;  // values a_s takes on the coming edge
    logic [3:0] r_q;

    assign a_in = {A4, A3, A2, A1};
    assign {R4, R3, R2, R1} = r_q;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        state_t                 state;
        logic [7:0]             hold_cnt;
        logic                   r;
        logic                   g;
        logic                   to_flag;
        logic                   ab_flag;

        // NOTE: synchroniser flops are reset like any other state so that a
        // stale acknowledge cannot reach a freshly reset FSM.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], a_in[i]};
            end
        end

        assign a_s[i]   = sync_q[SYNC_STAGES-1];
        assign a_pre[i] = sync_q[SYNC_STAGES-2];

        // R and grant are registered alongside the state so the outputs
        // change on the same edge as the transition that implies them.
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                hold_cnt <= '0;
                r        <= 1'b0;
                g        <= 1'b0;
                to_flag  <= 1'b0;
                ab_flag  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req[i]) begin
                            state <= REQ;
                            r     <= 1'b1;
                        end
                    end
                    REQ: begin
                        // R is held until the acknowledge arrives, even if
                        // the client withdrew its request in the meantime.
                        if (a_s[i]) begin
                            if (req[i]) begin
                                state    <= GRANT;
                                g        <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                state   <= REL;
                                r       <= 1'b0;
                                ab_flag <= 1'b1;
                            end
                        end
                    end
                    GRANT: begin
                        // done wins over a coincident timeout.
                        if (done[i]) begin
                            state    <= REL;
                            r        <= 1'b0;
                            g        <= 1'b0;
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state    <= REL;
                            r        <= 1'b0;
                            g        <= 1'b0;
                            hold_cnt <= '0;
                            to_flag  <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    REL: begin
                        if (!a_s[i]) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        r     <= 1'b0;
                        g     <= 1'b0;
                    end
                endcase
            end
        end

        assign r_q[i]     = r;
        assign grant[i]   = g;
        assign timeout[i] = to_flag;
        assign abort[i]   = ab_flag;
    end

    // Flag is raised on the same edge that two or more a_s bits go high,
    // by looking at the stage that feeds a_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excl_err <= 1'b0;
        end else if ($countones(a_pre) > 1) begin
            excl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_frontend4.sv
// -----------------------------------------------------------------------------
// tb_arb_req_frontend4
//
// Directed bench for arb_req_frontend4 (SYNC_STAGES=2, MAX_HOLD=8). A small
// arbiter model answers R with A at the falling clock edge (one acknowledge
// at a time, round robin, optional delay); it can be bypassed to force
// acknowledges directly. Edge numbers in comments count rising edges after
// the stimulus of a step was applied (that application point is edge 0).
// -----------------------------------------------------------------------------
module tb_arb_req_frontend4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic       A4, A3, A2, A1;
    logic       R4, R3, R2, R1;
    logic [3:0] grant;
    logic [3:0] timeout;
    logic [3:0] abort;
    logic       excl_err;

    logic [3:0] r_vec;
    logic [3:0] ack_model;
    logic [3:0] ack_force;
    logic       arb_en;
    int         ack_delay;
    int         wait_cnt;
    int         rr_ptr;

    int vectors;
    int miscompares;

    arb_req_frontend4 #(
        .SYNC_STAGES(2),
        .MAX_HOLD   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .A4      (A4),
        .A3      (A3),
        .A2      (A2),
        .A1      (A1),
        .R4      (R4),
        .R3      (R3),
        .R2      (R2),
        .R1      (R1),
        .grant   (grant),
        .timeout (timeout),
        .abort   (abort),
        .excl_err(excl_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign r_vec = {R4, R3, R2, R1};
    assign {A4, A3, A2, A1} = arb_en ? ack_model : ack_force;

    // Arbiter model: drop an acknowledge once its request is gone; when no
    // acknowledge is high, grant the next pending request in round-robin
    // order after ack_delay falling edges of waiting.
    initial begin
        ack_model = 4'b0000;
        wait_cnt  = 0;
        rr_ptr    = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ack_model[i] && !r_vec[i]) ack_model[i] = 1'b0;
            end
            if (arb_en && ack_model == 4'b0000) begin
                int idx;
                idx = -1;
                for (int k = 0; k < 4; k++) begin
                    if (idx < 0 && r_vec[(rr_ptr + k) % 4]) idx = (rr_ptr + k) % 4;
                end
                if (idx < 0) begin
                    wait_cnt = 0;
                end else if (wait_cnt >= ack_delay) begin
                    ack_model[idx] = 1'b1;
                    rr_ptr         = (idx + 1) % 4;
                    wait_cnt       = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] seen;
        logic [3:0] granted;
        int         bad_onehot;
        int         gc [4];
        int         hi_cnt;
        logic       r_at_fall;
        logic       prev_g;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = 4'b0000;
        done        = 4'b0000;
        ack_force   = 4'b0000;
        arb_en      = 1'b1;
        ack_delay   = 0;

        // ---------------- reset state ----------------
        tick(2);
        check("rst_r", 8'(r_vec), 8'h0);
        check("rst_grant", 8'(grant), 8'h0);
        check("rst_flags", {timeout, abort}, 8'h00);
        check("rst_excl", 8'(excl_err), 8'h0);
        rst = 1'b0;

        // ---------------- single request, immediate ack ----------------
        req = 4'b0001;
        tick();                                   // edge 1
        check("single_r1_e1", 8'(r_vec), 8'h1);
        tick(2);                                  // edge 3
        check("single_nogrant_e3", 8'(grant), 8'h0);
        tick();                                   // edge 4
        check("single_grant_e4", 8'(grant), 8'h1);
        tick(5);                                  // edge 9
        check("single_grant_e9", 8'(grant), 8'h1);
        done = 4'b0001;
        req  = 4'b0000;
        tick();                                   // edge 10
        check("single_done_grant", 8'(grant), 8'h0);
        check("single_done_r", 8'(r_vec), 8'h0);
        done = 4'b0000;
        tick();                                   // edge 11, A1 fell before it
        req = 4'b0001;
        tick();                                   // edge 12: still REL
        check("rel_hold_r", 8'(r_vec), 8'h0);
        tick();                                   // edge 13: IDLE
        check("idle_gap_r", 8'(r_vec), 8'h0);
        tick();                                   // edge 14: REQ again
        check("rereq_r", 8'(r_vec), 8'h1);

        // done on the same edge the hold limit is reached: no timeout.
        // Grant runs edges 17..24; edge 25 is the forced-release edge.
        tick(10);                                 // edge 24
        check("coinc_grant_e24", 8'(grant), 8'h1);
        done = 4'b0001;
        req  = 4'b0000;
        tick();                                   // edge 25
        check("coinc_grant_off", 8'(grant), 8'h0);
        check("coinc_no_timeout", 8'(timeout), 8'h0);
        done = 4'b0000;
        tick(6);

        // ---------------- timeout on channel 3 ----------------
        req       = 4'b0100;
        hi_cnt    = 0;
        r_at_fall = 1'b1;
        prev_g    = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (grant[2]) hi_cnt++;
            if (prev_g && !grant[2]) r_at_fall = R3;
            prev_g = grant[2];
        end
        check("timeout_hold_cycles", 8'(hi_cnt), 8'd8);
        check("timeout_r3_drop", 8'(r_at_fall), 8'h0);
        check("timeout_flag", 8'(timeout), 8'h4);
        req = 4'b0000;
        tick(10);

        // ---------------- abort: 1-cycle request, ack delayed 5 ----------------
        ack_delay = 5;
        req       = 4'b0010;
        tick();                                   // edge 1
        check("abort_r2_e1", 8'(r_vec), 8'h2);
        req  = 4'b0000;
        seen = 4'b0000;
        for (int c = 0; c < 7; c++) begin         // edges 2..8
            tick();
            seen = seen | grant;
        end
        check("abort_r2_held_e8", 8'(r_vec[1]), 8'h1);
        tick();                                   // edge 9: a_s seen, req low
        seen = seen | grant;
        check("abort_r2_drop_e9", 8'(r_vec[1]), 8'h0);
        check("abort_no_grant", 8'(seen), 8'h0);
        check("abort_flag", 8'(abort), 8'h2);
        ack_delay = 0;
        tick(4);                                  // edge 13: back in IDLE
        req = 4'b0010;
        tick();
        check("abort_idle_rereq", 8'(r_vec), 8'h2);
        req = 4'b0000;
        tick(8);

        // ---------------- contention: all four requesting ----------------
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        req        = 4'b1111;
        granted    = 4'b0000;
        bad_onehot = 0;
        for (int i = 0; i < 4; i++) gc[i] = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if ((grant & (grant - 4'd1)) != 4'b0000) bad_onehot++;
            granted = granted | grant;
            for (int i = 0; i < 4; i++) begin
                gc[i]   = grant[i] ? gc[i] + 1 : 0;
                done[i] = grant[i] && (gc[i] >= 3);
            end
        end
        check("contend_onehot", 8'(bad_onehot), 8'd0);
        check("contend_all_granted", 8'(granted), 8'hF);
        check("contend_excl", 8'(excl_err), 8'h0);
        req  = 4'b0000;
        done = 4'b0000;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        tick(2);

        // ---------------- exclusion fault ----------------
        arb_en    = 1'b0;
        ack_force = 4'b0101;
        tick();                                   // edge 1
        check("excl_e1", 8'(excl_err), 8'h0);
        tick();                                   // edge 2
        check("excl_e2", 8'(excl_err), 8'h1);
        ack_force = 4'b0000;
        tick(5);
        check("excl_sticky", 8'(excl_err), 8'h1);
        arb_en = 1'b1;
        tick();

        // ---------------- reset mid-GRANT on channel 4 ----------------
        req = 4'b1000;
        tick(4);
        check("rstmid_grant", 8'(grant), 8'h8);
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_r", 8'(r_vec), 8'h0);
        check("rstmid_grant_off", 8'(grant), 8'h0);
        check("rstmid_flags", {timeout, abort}, 8'h00);
        check("rstmid_excl", 8'(excl_err), 8'h0);
        req = 4'b0000;
        tick(2);
        rst  = 1'b0;
        seen = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | r_vec;
        end
        check("post_rst_quiet", 8'(seen), 8'h0);
        rst = 1'b1;
        tick();
        req = 4'b1000;
        rst = 1'b0;
        tick();
        check("post_rst_rereq", 8'(r_vec), 8'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
